// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 16550-style UART transmitter.
//
// Pulls bytes from a first-word-fall-through TX FIFO and serialises each one as
// start bit, 5-8 data bits (LSB first), optional parity bit and 1/1.5/2 stop
// bits. The bit clock is TICKS_PER_BIT baud_pulse strobes per bit.
//
// Optional feature: define UART_TX_HALF_STOP_EN to make stb=1 with a 5-bit word
// length produce a 1.5-bit stop period. Without it, stb=1 always gives two
// full stop bits.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-low reset
//   baud_pulse     one-clk strobe at TICKS_PER_BIT x baud rate
//   din[7:0]       FIFO head data, valid whenever fifo_empty=0
//   fifo_empty     TX FIFO empty flag
//   pop            one-clk FIFO read strobe
//   wls[1:0]       word length: 00=5, 01=6, 10=7, 11=8 bits
//   stb            0 = 1 stop bit, 1 = 2 stop bits (1.5 for wls=00 with macro)
//   pen            parity enable
//   eps            1 = even parity, 0 = odd parity
//   sticky_parity  parity bit forced to ~eps
//   break_ctl      force line low
//   tx             serial output, idle high
//   sreg_empty     transmitter idle (TEMT)
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module uart_tx #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [7:0] din,
  input  logic       fifo_empty,
  output logic       pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       break_ctl,
  output logic       tx,
  output logic       sreg_empty
);

  localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
`ifdef UART_TX_HALF_STOP_EN
  localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(TICKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [1:0]        wls_q;
  logic              stb_q;
  logic              pen_q;
  logic              par_q;
  logic              bit_done;
  logic              last_data;
  logic              stop_done;
  logic              line;
  logic [7:0]        din_masked;
  logic              par_bit;

  assign bit_done  = baud_pulse && (tick_cnt == TICK_LAST);
  assign last_data = (bit_cnt == (3'd4 + {1'b0, wls_q}));

  // stop_done marks the final baud tick of the stop period. During the stop
  // period bit_cnt counts completed stop bits, so one stop bit ends at the
  // first bit boundary and two stop bits end at the second.
  always_comb begin
    stop_done = bit_done && (bit_cnt == {2'b00, stb_q});
`ifdef UART_TX_HALF_STOP_EN
    if (stb_q && (wls_q == 2'b00))
      stop_done = baud_pulse && (bit_cnt == 3'd1) && (tick_cnt == TICK_HALF_LAST);
`endif
  end

  // Parity is resolved when the byte is taken so that later changes to
  // eps/sticky_parity cannot reach the frame in progress.
  always_comb begin
    case (wls)
      2'b00:   din_masked = {3'b000, din[4:0]};
      2'b01:   din_masked = {2'b00, din[5:0]};
      2'b10:   din_masked = {1'b0, din[6:0]};
      default: din_masked = din;
    endcase
    par_bit = sticky_parity ? ~eps : (eps ? ^din_masked : ~^din_masked);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // next_state unassigned and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:   if (!fifo_empty) next_state = S_START;
      S_START:  if (bit_done) next_state = S_DATA;
      S_DATA:   if (bit_done && last_data) next_state = pen_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) next_state = S_STOP;
      S_STOP:   if (stop_done) next_state = fifo_empty ? S_IDLE : S_START;
      default:  next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (decoded from registered state only, plus the FIFO flag for pop)
  // ---------------------------------------------------------------------------
  always_comb begin
    line       = 1'b1;
    sreg_empty = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        sreg_empty = 1'b1;
        pop        = !fifo_empty;
      end
      S_START:  line = 1'b0;
      S_DATA:   line = shreg[0];
      S_PARITY: line = par_q;
      S_STOP:   pop = stop_done && !fifo_empty;
      default:  line = 1'b1;
    endcase
    // The FIFO must not lose a byte while the transmitter is held in reset.
    if (!rst) pop = 1'b0;
  end

  // Break overrides the line without disturbing the frame timing underneath.
  assign tx = line & ~break_ctl;

  // ---------------------------------------------------------------------------
  // Tick and bit counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (pop || (state == S_IDLE)) begin
      // A baud tick coinciding with pop is dropped on purpose: the new frame
      // starts its first bit period from a clean count.
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (baud_pulse) begin
      if (bit_done || ((state == S_STOP) && stop_done)) tick_cnt <= '0;
      else                                              tick_cnt <= tick_cnt + 1'b1;
      if (bit_done) begin
        if ((state == S_DATA) && last_data)      bit_cnt <= '0;
        else if (state inside {S_DATA, S_STOP})  bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers and shift register
  // ---------------------------------------------------------------------------
  // NOTE: no reset here -- these are always loaded on pop before the FSM can
  // read them, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= din;
      wls_q <= wls;
      stb_q <= stb;
      pen_q <= pen;
      par_q <= par_bit;
    end else if ((state == S_DATA) && bit_done) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Expected line waveforms come from a per-tick model built from the frame
// rules (start, data LSB first, parity, stop length), indexed by the number of
// baud ticks the DUT has seen since the pop edge.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_uart_tx;

  localparam int TPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sticky;
  } cfg_t;

  logic       clk;
  logic       rst;
  logic       baud_pulse;
  logic [7:0] din;
  logic       fifo_empty;
  logic       pop;
  logic [1:0] wls;
  logic       stb;
  logic       pen;
  logic       eps;
  logic       sticky_parity;
  logic       break_ctl;
  logic       tx;
  logic       sreg_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int baud_div = 6;
  int fid      = 0;
  bit exp_q[$];

  uart_tx #(.TICKS_PER_BIT(TPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .din           (din),
    .fifo_empty    (fifo_empty),
    .pop           (pop),
    .wls           (wls),
    .stb           (stb),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .break_ctl     (break_ctl),
    .tx            (tx),
    .sreg_empty    (sreg_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud strobe: one clk high every baud_div clocks, changed just after posedge.
  initial begin
    int div;
    div = 0;
    baud_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_pulse = (div == baud_div - 1);
      div = (div + 1 >= baud_div) ? 0 : div + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int idx, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
    end
  endtask

  // Per-tick model of one frame.
  function automatic void build_model(input cfg_t c);
    int n;
    int stop_ticks;
    bit p;
    logic [7:0] mask;
    exp_q.delete();
    n = 5 + int'(c.wls);
    repeat (TPB) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++)
      repeat (TPB) exp_q.push_back(c.data[i]);
    if (c.pen) begin
      mask = 8'((9'd1 << n) - 9'd1);
      p = ^(c.data & mask);
      repeat (TPB) exp_q.push_back(c.sticky ? !c.eps : (c.eps ? p : !p));
    end
    stop_ticks = c.stb ? 2 * TPB : TPB;
`ifdef UART_TX_HALF_STOP_EN
    if (c.stb && c.wls == 2'b00) stop_ticks = TPB + TPB / 2;
`endif
    repeat (stop_ticks) exp_q.push_back(1'b1);
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.data   = 8'($urandom);
    c.wls    = 2'($urandom_range(0, 3));
    c.stb    = 1'($urandom_range(0, 1));
    c.pen    = 1'($urandom_range(0, 1));
    c.eps    = 1'($urandom_range(0, 1));
    c.sticky = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic apply_cfg(input cfg_t c);
    din           = c.data;
    wls           = c.wls;
    stb           = c.stb;
    pen           = c.pen;
    eps           = c.eps;
    sticky_parity = c.sticky;
  endtask

  // Entered at a negedge where pop is expected high. Checks the whole frame;
  // returns at the negedge of its final cycle (or at abort_tick). After the
  // pop edge the inputs are switched to nxt, with the FIFO non-empty if
  // nxt_valid. brk_tick >= 0 pulses break_ctl for 40 clk from that tick.
  task automatic run_frame(input cfg_t cur, input cfg_t nxt, input bit nxt_valid,
                           input int brk_tick, input int abort_tick);
    int  ticks;
    int  brk_cycles;
    int  total;
    bit  last;
    fid++;
    build_model(cur);
    total = exp_q.size();
    ticks = 0;
    brk_cycles = 0;
    #1;
    check("pop_start", fid, pop, 1'b1);
    @(posedge clk);
    #1;
    apply_cfg(nxt);
    fifo_empty = !nxt_valid;
    forever begin
      @(negedge clk);
      if (ticks == abort_tick) begin
        break_ctl = 1'b0;
        return;
      end
      last = (ticks == total - 1) && baud_pulse;
      check("tx", fid, tx, break_ctl ? 1'b0 : exp_q[ticks]);
      check("temt_busy", fid, sreg_empty, 1'b0);
      check("pop", fid, pop, last && nxt_valid);
      if (last) begin
        break_ctl = 1'b0;
        return;
      end
      if (brk_tick >= 0 && ticks >= brk_tick && brk_cycles < 40) begin
        break_ctl = 1'b1;
        brk_cycles++;
      end else begin
        break_ctl = 1'b0;
      end
      @(posedge clk);
      if (baud_pulse) ticks++;
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_temt", fid, sreg_empty, 1'b1);
    check("idle_tx", fid, tx, 1'b1);
    check("idle_pop", fid, pop, 1'b0);
  endtask

  task automatic start_frame(input cfg_t c);
    apply_cfg(c);
    fifo_empty = 1'b0;
  endtask

  initial begin
    cfg_t c;
    cfg_t c2;
    cfg_t j;
    bit   v;

    rst = 1'b0; din = 8'h00; fifo_empty = 1'b0; wls = 2'b00; stb = 1'b0;
    pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; break_ctl = 1'b0;

    // Reset state, with the FIFO non-empty so pop must stay suppressed.
    repeat (3) @(negedge clk);
    check("rst_tx", 0, tx, 1'b1);
    check("rst_pop", 0, pop, 1'b0);
    check("rst_temt", 0, sreg_empty, 1'b1);
    fifo_empty = 1'b1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_pop_empty", 0, pop, 1'b0);
    check("idle_temt0", 0, sreg_empty, 1'b1);
    check("idle_tx0", 0, tx, 1'b1);

    // 8-bit odd parity, 0x45.
    c = '{data: 8'h45, wls: 2'd3, stb: 1'b0, pen: 1'b1, eps: 1'b0, sticky: 1'b0};
    start_frame(c);
    run_frame(c, rand_cfg(), 1'b0, -1, -1);
    idle_check();

    // 5-bit even parity, 2 stop bits (1.5 with the half-stop feature).
    c = '{data: 8'hFF, wls: 2'd0, stb: 1'b1, pen: 1'b1, eps: 1'b1, sticky: 1'b0};
    start_frame(c);
    run_frame(c, rand_cfg(), 1'b0, -1, -1);
    idle_check();

    // Sticky parity; eps flips right after the pop edge.
    c = '{data: 8'h00, wls: 2'd3, stb: 1'b0, pen: 1'b1, eps: 1'b1, sticky: 1'b1};
    j = c; j.eps = 1'b0;
    start_frame(c);
    run_frame(c, j, 1'b0, -1, -1);
    idle_check();
    c.eps = 1'b0; j.eps = 1'b1;
    start_frame(c);
    run_frame(c, j, 1'b0, -1, -1);
    idle_check();

    // Back-to-back 0xA5 then 0x3C, no parity.
    c  = '{data: 8'hA5, wls: 2'd3, stb: 1'b0, pen: 1'b0, eps: 1'b0, sticky: 1'b0};
    c2 = '{data: 8'h3C, wls: 2'd3, stb: 1'b0, pen: 1'b0, eps: 1'b0, sticky: 1'b0};
    start_frame(c);
    run_frame(c, c2, 1'b1, -1, -1);
    run_frame(c2, rand_cfg(), 1'b0, -1, -1);
    idle_check();

    // Break for 40 clk inside data bit 3.
    c = '{data: 8'hFF, wls: 2'd3, stb: 1'b0, pen: 1'b1, eps: 1'b1, sticky: 1'b0};
    start_frame(c);
    run_frame(c, rand_cfg(), 1'b0, 4 * TPB + 2, -1);
    idle_check();

    // Reset during the parity bit, then a fresh frame after release.
    c  = '{data: 8'h5A, wls: 2'd3, stb: 1'b0, pen: 1'b1, eps: 1'b0, sticky: 1'b0};
    c2 = '{data: 8'hC3, wls: 2'd2, stb: 1'b1, pen: 1'b1, eps: 1'b1, sticky: 1'b0};
    start_frame(c);
    run_frame(c, rand_cfg(), 1'b0, -1, 9 * TPB + 5);
    rst = 1'b0;
    start_frame(c2);
    @(negedge clk);
    check("midrst_tx", fid, tx, 1'b1);
    check("midrst_pop", fid, pop, 1'b0);
    check("midrst_temt", fid, sreg_empty, 1'b1);
    rst = 1'b1;
    run_frame(c2, rand_cfg(), 1'b0, -1, -1);
    idle_check();

    // baud_pulse every clk: a tick always coincides with the pop edge.
    baud_div = 1;
    c = '{data: 8'h96, wls: 2'd1, stb: 1'b1, pen: 1'b1, eps: 1'b0, sticky: 1'b0};
    start_frame(c);
    run_frame(c, rand_cfg(), 1'b0, -1, -1);
    idle_check();

    // Random chain with random back-to-back and baud rates.
    baud_div = int'($urandom_range(1, 4));
    c = rand_cfg();
    start_frame(c);
    for (int i = 0; i < 14; i++) begin
      c2 = rand_cfg();
      v  = (i < 13) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(c, c2, v, -1, -1);
      if (!v) begin
        idle_check();
        if (i < 13) begin
          baud_div = int'($urandom_range(1, 4));
          fifo_empty = 1'b0;
        end
      end
      c = c2;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
